// File: rtl/sigma_delta_cic_decimator_mc_pkg.sv
// sigma_delta_pkg
// Shared definitions for the multi-channel sigma-delta CIC decimator:
//   - comb_state_t : states of the time-multiplexed comb engine
//   - min_wdth()   : smallest accumulator width that holds BOSR**STGS
//   - chan_idx_w() : width of a channel index (at least one bit)
//   - CHAN_W       : channel-index width for the default channel count
package sigma_delta_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        COMB = 2'd1,
        PUSH = 2'd2
    } comb_state_t;

    // One extra bit beyond STGS*log2(BOSR) so full scale (BOSR**STGS) is representable.
    function automatic int min_wdth(input int stgs, input int bosr);
        return stgs * $clog2(bosr) + 1;
    endfunction

    function automatic int chan_idx_w(input int chan);
        return (chan > 1) ? $clog2(chan) : 1;
    endfunction

    localparam int DEFAULT_CHAN = 4;
    localparam int CHAN_W       = chan_idx_w(DEFAULT_CHAN);

endpackage

// File: rtl/sigma_delta_cic_decimator_mc_if.sv
// sigma_delta_cic_decimator_mc_if
// Output stream of the decimator.
//   dec_data     : unsigned decimated sample
//   dec_chan     : channel index of dec_data
//   dec_valid    : FIFO head valid
//   dec_ready    : consumer accepts head when dec_valid && dec_ready
//   dec_overflow : sticky, a word was dropped
// master = decimator side, slave = consumer side.
interface sigma_delta_cic_decimator_mc_if
    import sigma_delta_pkg::*;
#(
    parameter int WDTH = 18,
    parameter int CW   = CHAN_W
);
    logic [WDTH-1:0] dec_data;
    logic [CW-1:0]   dec_chan;
    logic            dec_valid;
    logic            dec_ready;
    logic            dec_overflow;

    modport master (
        output dec_data,
        output dec_chan,
        output dec_valid,
        output dec_overflow,
        input  dec_ready
    );

    modport slave (
        input  dec_data,
        input  dec_chan,
        input  dec_valid,
        input  dec_overflow,
        output dec_ready
    );
endinterface

// File: rtl/sigma_delta_cic_decimator_mc_fifo.sv
// sigma_delta_sync_fifo
// Single-clock show-ahead FIFO. The head word is presented on rd_data while
// rd_valid is high and leaves when rd_ready is also high.
//   clk, rst : clock, synchronous active-high reset
//   wr_en    : write wr_data (ignored while full)
//   full     : no free entry
//   rd_valid : head word present
//   rd_ready : consumer takes head word
//   rd_data  : head word
module sigma_delta_sync_fifo #(
    parameter int WDTH  = 8,
    parameter int DEPTH = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            wr_en,
    input  logic [WDTH-1:0] wr_data,
    output logic            full,
    output logic            rd_valid,
    input  logic            rd_ready,
    output logic [WDTH-1:0] rd_data
);
    localparam int AW = $clog2(DEPTH);

    logic [WDTH-1:0] mem [DEPTH];
    logic [AW:0]     wr_ptr;
    logic [AW:0]     rd_ptr;
    logic            do_wr;
    logic            do_rd;

    // Pointers carry one wrap bit so full and empty are distinguishable.
    assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign rd_valid = (wr_ptr != rd_ptr);
    assign rd_data  = mem[rd_ptr[AW-1:0]];
    assign do_wr    = wr_en && !full;
    assign do_rd    = rd_valid && rd_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (do_wr) begin
                mem[wr_ptr[AW-1:0]] <= wr_data;
                wr_ptr              <= wr_ptr + 1'b1;
            end
            if (do_rd) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
        end
    end
endmodule

// File: rtl/sigma_delta_cic_decimator_mc.sv
// sigma_delta_cic_decimator_mc
// CHAN parallel 1-bit sigma-delta streams -> WDTH-bit unsigned PCM at 1/BOSR
// of the bit rate. Per-channel integrator cascades run in parallel; one comb
// engine is shared by all channels; results leave through a valid/ready FIFO.
//   clk    : bit clock
//   rst    : synchronous active-high reset
//   bit_en : pdm_in valid this cycle
//   pdm_in : one bit per channel (1 -> +1, 0 -> 0)
//   dec    : output stream (data, channel, valid/ready, sticky overflow)
module sigma_delta_cic_decimator_mc
    import sigma_delta_pkg::*;
#(
    parameter int BOSR       = 256,
    parameter int STGS       = 2,
    parameter int CHAN       = 4,
    parameter int WDTH       = 2 + STGS * $clog2(BOSR),
    parameter int FIFO_DEPTH = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 bit_en,
    input  logic [CHAN-1:0]      pdm_in,
    sigma_delta_cic_decimator_mc_if.master dec
);
    localparam int CW    = chan_idx_w(CHAN);
    localparam int CNT_W = $clog2(BOSR);
    localparam int STG_W = (STGS > 1) ? $clog2(STGS) : 1;
    localparam int FRM_W = $clog2(STGS + 1);

    if (WDTH < min_wdth(STGS, BOSR)) begin : g_err_wdth
        $error("WDTH is too small for BOSR**STGS");
    end
    if (BOSR < CHAN * (STGS + 1) + 2) begin : g_err_bosr
        $error("BOSR too small for the shared comb engine to finish every channel");
    end
    if (BOSR < 2 || (BOSR & (BOSR - 1)) != 0) begin : g_err_pow2
        $error("BOSR must be a power of two >= 2");
    end
    if (STGS < 1 || STGS > 5) begin : g_err_stgs
        $error("STGS must be 1..5");
    end
    if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_err_depth
        $error("FIFO_DEPTH must be a power of two >= 2");
    end

    logic [WDTH-1:0]  integ      [CHAN][STGS];
    logic [WDTH-1:0]  integ_next [CHAN][STGS];
    logic [WDTH-1:0]  snap       [CHAN];
    logic [WDTH-1:0]  delay      [CHAN][STGS];
    logic [WDTH-1:0]  acc_q;
    logic [WDTH-1:0]  comb_in;
    logic [WDTH-1:0]  comb_out;
    logic [CNT_W-1:0] cnt_q;
    logic [FRM_W-1:0] frm_q;
    logic             boundary;
    logic             suppress;
    logic             ovf_q;

    comb_state_t      state_q, state_d;
    logic [CW-1:0]    ch_q, ch_d;
    logic [STG_W-1:0] stg_q, stg_d;
    logic             comb_en;
    logic             push;
    logic             last_push;

    logic             fifo_wr;
    logic             fifo_full;
    logic [CW+WDTH-1:0] fifo_rd_data;

    assign boundary = bit_en && (cnt_q == CNT_W'(BOSR - 1));
    assign suppress = (frm_q < FRM_W'(STGS));
    assign fifo_wr  = push && !suppress && !fifo_full;

    // Cascaded integrators: each stage adds the previous stage's pre-update value.
    always_comb begin
        for (int c = 0; c < CHAN; c++) begin
            integ_next[c][0] = integ[c][0] + WDTH'(pdm_in[c]);
            for (int k = 1; k < STGS; k++) begin
                integ_next[c][k] = integ[c][k] + integ[c][k-1];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int c = 0; c < CHAN; c++) begin
                for (int k = 0; k < STGS; k++) begin
                    integ[c][k] <= '0;
                end
            end
        end else if (bit_en) begin
            integ <= integ_next;
        end
    end

    // Decimation counter and snapshot; the snapshot takes the post-update
    // value so the boundary bit is part of the frame. A boundary that lands
    // while the comb engine is busy is dropped rather than corrupting it.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
            for (int c = 0; c < CHAN; c++) begin
                snap[c] <= '0;
            end
        end else begin
            if (bit_en) begin
                cnt_q <= cnt_q + 1'b1;
            end
            if (boundary && state_q == IDLE) begin
                for (int c = 0; c < CHAN; c++) begin
                    snap[c] <= integ_next[c][STGS-1];
                end
            end
        end
    end

    // Comb FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            ch_q    <= '0;
            stg_q   <= '0;
        end else begin
            state_q <= state_d;
            ch_q    <= ch_d;
            stg_q   <= stg_d;
        end
    end

    // Comb FSM: STGS comb cycles then one PUSH cycle per channel.
    always_comb begin
        state_d   = state_q;
        ch_d      = ch_q;
        stg_d     = stg_q;
        comb_en   = 1'b0;
        push      = 1'b0;
        last_push = 1'b0;
        case (state_q)
            IDLE: begin
                if (boundary) begin
                    state_d = COMB;
                    ch_d    = '0;
                    stg_d   = '0;
                end
            end
            COMB: begin
                comb_en = 1'b1;
                if (stg_q == STG_W'(STGS - 1)) begin
                    state_d = PUSH;
                end else begin
                    stg_d = stg_q + 1'b1;
                end
            end
            PUSH: begin
                push  = 1'b1;
                stg_d = '0;
                if (ch_q == CW'(CHAN - 1)) begin
                    state_d   = IDLE;
                    last_push = 1'b1;
                end else begin
                    ch_d    = ch_q + 1'b1;
                    state_d = COMB;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Stage 0 reads the channel snapshot; later stages chain through acc_q.
    assign comb_in  = (stg_q == '0) ? snap[ch_q] : acc_q;
    assign comb_out = comb_in - delay[ch_q][stg_q];

    always_ff @(posedge clk) begin
        if (rst) begin
            acc_q <= '0;
            for (int c = 0; c < CHAN; c++) begin
                for (int k = 0; k < STGS; k++) begin
                    delay[c][k] <= '0;
                end
            end
        end else if (comb_en) begin
            delay[ch_q][stg_q] <= comb_in;
            acc_q              <= comb_out;
        end
    end

    // Settling frame count and sticky overflow.
    always_ff @(posedge clk) begin
        if (rst) begin
            frm_q <= '0;
            ovf_q <= 1'b0;
        end else begin
            if (last_push && suppress) begin
                frm_q <= frm_q + 1'b1;
            end
            if ((push && !suppress && fifo_full) || (boundary && state_q != IDLE)) begin
                ovf_q <= 1'b1;
            end
        end
    end

    sigma_delta_sync_fifo #(
        .WDTH  (CW + WDTH),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .wr_en    (fifo_wr),
        .wr_data  ({ch_q, acc_q}),
        .full     (fifo_full),
        .rd_valid (dec.dec_valid),
        .rd_ready (dec.dec_ready),
        .rd_data  (fifo_rd_data)
    );

    assign dec.dec_chan     = fifo_rd_data[CW+WDTH-1 -: CW];
    assign dec.dec_data     = fifo_rd_data[WDTH-1:0];
    assign dec.dec_overflow = ovf_q;

endmodule

// File: tb/tb_sigma_delta_cic_decimator_mc.sv
// tb_sigma_delta_cic_decimator_mc
// Self-checking bench for sigma_delta_cic_decimator_mc with BOSR=16, STGS=2,
// CHAN=2, WDTH=10, FIFO_DEPTH=4. Expected words are queued when the bench
// drives a frame boundary and compared against the words the DUT hands out.
module tb_sigma_delta_cic_decimator_mc;
    import sigma_delta_pkg::*;

    localparam int BOSR       = 16;
    localparam int STGS       = 2;
    localparam int CHAN       = 2;
    localparam int WDTH       = 10;
    localparam int FIFO_DEPTH = 4;
    localparam int CW         = chan_idx_w(CHAN);
    localparam int FULL_SCALE = BOSR ** STGS;

    typedef struct packed {
        logic [CW-1:0]   ch;
        logic [WDTH-1:0] data;
    } word_t;

    logic            clk = 1'b0;
    logic            rst;
    logic            bit_en;
    logic [CHAN-1:0] pdm_in;

    sigma_delta_cic_decimator_mc_if #(.WDTH(WDTH), .CW(CW)) dec_if ();

    sigma_delta_cic_decimator_mc #(
        .BOSR       (BOSR),
        .STGS       (STGS),
        .CHAN       (CHAN),
        .WDTH       (WDTH),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .bit_en (bit_en),
        .pdm_in (pdm_in),
        .dec    (dec_if)
    );

    // Free-running bit clock.
    always #5 clk = ~clk;

    int              checks = 0;
    int              errors = 0;
    int              cyc = 0;
    int              bit_cnt = 0;
    int              frames = 0;
    int              b_cyc = 0;
    bit              auto_exp = 1'b0;
    logic            toggle_bit = 1'b1;
    logic [WDTH-1:0] exp_word [CHAN];
    word_t           exp_q[$];
    word_t           got_q[$];
    int              got_cyc[$];

    // Drives one cycle from a negedge, records any accepted word, and tracks
    // frame boundaries so expected words are queued as the frame completes.
    task automatic applyStimulus(input logic en, input logic [CHAN-1:0] bits);
        word_t w;
        bit_en = en;
        pdm_in = bits;
        if (!rst && dec_if.dec_valid && dec_if.dec_ready) begin
            w.ch   = dec_if.dec_chan;
            w.data = dec_if.dec_data;
            got_q.push_back(w);
            got_cyc.push_back(cyc);
        end
        if (en && !rst) begin
            if (bit_cnt == BOSR - 1) begin
                bit_cnt = 0;
                frames++;
                b_cyc = cyc;
                if (auto_exp && frames > STGS) begin
                    for (int c = 0; c < CHAN; c++) begin
                        w.ch   = CW'(c);
                        w.data = exp_word[c];
                        exp_q.push_back(w);
                    end
                end
            end else begin
                bit_cnt++;
            end
        end
        @(posedge clk);
        cyc++;
        @(negedge clk);
    endtask

    task automatic applyReset();
        rst = 1'b1;
        applyStimulus(1'b0, '0);
        rst        = 1'b0;
        bit_cnt    = 0;
        frames     = 0;
        toggle_bit = 1'b1;
        exp_q.delete();
        got_q.delete();
        got_cyc.delete();
    endtask

    // mode 0: all ones; mode 1: ch0 held at 0, ch1 toggles 1/0 per bit.
    task automatic run_bits(input int nbits, input int period, input int mode);
        logic [CHAN-1:0] bits;
        for (int i = 0; i < nbits; i++) begin
            for (int p = 0; p < period - 1; p++) begin
                applyStimulus(1'b0, '0);
            end
            if (mode == 0) begin
                bits = '1;
            end else begin
                bits    = '0;
                bits[1] = toggle_bit;
                toggle_bit = ~toggle_bit;
            end
            applyStimulus(1'b1, bits);
        end
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            applyStimulus(1'b0, '0);
        end
    endtask

    task automatic test_reset();
        applyReset();
        checks++;
        if (dec_if.dec_valid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_valid: got %b, expected 0", dec_if.dec_valid);
        end
        checks++;
        if (dec_if.dec_overflow !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_overflow: got %b, expected 0", dec_if.dec_overflow);
        end
        checks++;
        if (dec_if.dec_data !== '0) begin
            errors++;
            $display("[TB] FAIL reset_data: got %0d, expected 0", dec_if.dec_data);
        end
        checks++;
        if (dec_if.dec_chan !== '0) begin
            errors++;
            $display("[TB] FAIL reset_chan: got %0d, expected 0", dec_if.dec_chan);
        end
    endtask

    task automatic test_all_ones();
        applyReset();
        dec_if.dec_ready = 1'b1;
        auto_exp    = 1'b1;
        exp_word[0] = WDTH'(FULL_SCALE);
        exp_word[1] = WDTH'(FULL_SCALE);
        run_bits(5 * BOSR, 1, 0);
        idle_cycles(20);
        checks++;
        if (got_q.size() != exp_q.size() || exp_q.size() != 6) begin
            errors++;
            $display("[TB] FAIL all_ones_count: got %0d words, expected 6 (queued %0d)", got_q.size(), exp_q.size());
        end
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
            checks++;
            if (got_q[i] !== exp_q[i]) begin
                errors++;
                $display("[TB] FAIL all_ones_word%0d: got ch%0d=%0d, expected ch%0d=%0d", i, got_q[i].ch, got_q[i].data, exp_q[i].ch, exp_q[i].data);
            end
        end
    endtask

    task automatic test_half_scale();
        applyReset();
        dec_if.dec_ready = 1'b1;
        auto_exp    = 1'b1;
        exp_word[0] = '0;
        exp_word[1] = WDTH'(FULL_SCALE / 2);
        run_bits(4 * BOSR, 1, 1);
        idle_cycles(20);
        checks++;
        if (got_q.size() != 4) begin
            errors++;
            $display("[TB] FAIL half_scale_count: got %0d words, expected 4", got_q.size());
        end
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
            checks++;
            if (got_q[i] !== exp_q[i]) begin
                errors++;
                $display("[TB] FAIL half_scale_word%0d: got ch%0d=%0d, expected ch%0d=%0d", i, got_q[i].ch, got_q[i].data, exp_q[i].ch, exp_q[i].data);
            end
        end
    endtask

    // First unsuppressed frame with the given bit_en spacing; the DUT must
    // show ch0 at B+4 and ch1 at B+7 regardless of spacing.
    task automatic test_latency(input int period, input string tag);
        int b;
        applyReset();
        dec_if.dec_ready = 1'b1;
        auto_exp    = 1'b1;
        exp_word[0] = WDTH'(FULL_SCALE);
        exp_word[1] = WDTH'(FULL_SCALE);
        run_bits(3 * BOSR, period, 0);
        b = b_cyc;
        idle_cycles(20);
        checks++;
        if (got_cyc.size() != 2) begin
            errors++;
            $display("[TB] FAIL %s_count: got %0d words, expected 2", tag, got_cyc.size());
        end else begin
            checks++;
            if (got_cyc[0] != b + 4) begin
                errors++;
                $display("[TB] FAIL %s_ch0_cycle: got B+%0d, expected B+4", tag, got_cyc[0] - b);
            end
            checks++;
            if (got_cyc[1] != b + 7) begin
                errors++;
                $display("[TB] FAIL %s_ch1_cycle: got B+%0d, expected B+7", tag, got_cyc[1] - b);
            end
            for (int i = 0; i < 2; i++) begin
                checks++;
                if (got_q[i] !== exp_q[i]) begin
                    errors++;
                    $display("[TB] FAIL %s_word%0d: got ch%0d=%0d, expected ch%0d=%0d", tag, i, got_q[i].ch, got_q[i].data, exp_q[i].ch, exp_q[i].data);
                end
            end
        end
    endtask

    task automatic test_backpressure();
        word_t w;
        int    b5;
        applyReset();
        dec_if.dec_ready = 1'b0;
        auto_exp = 1'b0;
        for (int i = 0; i < FIFO_DEPTH; i++) begin
            w.ch   = CW'(i % CHAN);
            w.data = WDTH'(FULL_SCALE);
            exp_q.push_back(w);
        end
        run_bits(5 * BOSR, 1, 0);
        b5 = b_cyc;
        applyStimulus(1'b1, '1);
        applyStimulus(1'b1, '1);
        bit_cnt = bit_cnt;
        checks++;
        if (cyc != b5 + 3 || dec_if.dec_overflow !== 1'b0) begin
            errors++;
            $display("[TB] FAIL bp_ovf_before: got %b at B+%0d, expected 0 at B+3", dec_if.dec_overflow, cyc - b5);
        end
        applyStimulus(1'b1, '1);
        checks++;
        if (dec_if.dec_overflow !== 1'b1) begin
            errors++;
            $display("[TB] FAIL bp_ovf_fifth_push: got %b, expected 1", dec_if.dec_overflow);
        end
        run_bits(2 * BOSR - 3 - 2, 1, 0);
        run_bits(2, 1, 0);
        idle_cycles(10);
        checks++;
        if (dec_if.dec_overflow !== 1'b1 || dec_if.dec_valid !== 1'b1) begin
            errors++;
            $display("[TB] FAIL bp_hold: got ovf=%b valid=%b, expected ovf=1 valid=1", dec_if.dec_overflow, dec_if.dec_valid);
        end
        dec_if.dec_ready = 1'b1;
        idle_cycles(12);
        checks++;
        if (got_q.size() != FIFO_DEPTH) begin
            errors++;
            $display("[TB] FAIL bp_drain_count: got %0d words, expected %0d", got_q.size(), FIFO_DEPTH);
        end
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
            checks++;
            if (got_q[i] !== exp_q[i]) begin
                errors++;
                $display("[TB] FAIL bp_word%0d: got ch%0d=%0d, expected ch%0d=%0d", i, got_q[i].ch, got_q[i].data, exp_q[i].ch, exp_q[i].data);
            end
        end
        checks++;
        if (dec_if.dec_overflow !== 1'b1) begin
            errors++;
            $display("[TB] FAIL bp_ovf_sticky: got %b, expected 1", dec_if.dec_overflow);
        end
    endtask

    task automatic test_reset_mid_comb();
        applyReset();
        dec_if.dec_ready = 1'b0;
        auto_exp = 1'b0;
        run_bits(6 * BOSR, 1, 0);
        checks++;
        if (dec_if.dec_overflow !== 1'b1 || dec_if.dec_valid !== 1'b1) begin
            errors++;
            $display("[TB] FAIL rst_pre: got ovf=%b valid=%b, expected ovf=1 valid=1", dec_if.dec_overflow, dec_if.dec_valid);
        end
        applyReset();
        checks++;
        if (dec_if.dec_valid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL rst_mid_valid: got %b, expected 0", dec_if.dec_valid);
        end
        checks++;
        if (dec_if.dec_overflow !== 1'b0) begin
            errors++;
            $display("[TB] FAIL rst_mid_overflow: got %b, expected 0", dec_if.dec_overflow);
        end
        dec_if.dec_ready = 1'b1;
        auto_exp    = 1'b1;
        exp_word[0] = WDTH'(FULL_SCALE);
        exp_word[1] = WDTH'(FULL_SCALE);
        run_bits(3 * BOSR, 1, 0);
        idle_cycles(20);
        checks++;
        if (got_q.size() != 2) begin
            errors++;
            $display("[TB] FAIL rst_after_count: got %0d words, expected 2", got_q.size());
        end
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
            checks++;
            if (got_q[i] !== exp_q[i]) begin
                errors++;
                $display("[TB] FAIL rst_after_word%0d: got ch%0d=%0d, expected ch%0d=%0d", i, got_q[i].ch, got_q[i].data, exp_q[i].ch, exp_q[i].data);
            end
        end
    endtask

    // Test sequence.
    initial begin
        rst              = 1'b1;
        bit_en           = 1'b0;
        pdm_in           = '0;
        dec_if.dec_ready = 1'b0;
        exp_word[0]      = '0;
        exp_word[1]      = '0;
        @(negedge clk);
        $display("[TB] starting");
        test_reset();
        test_all_ones();
        test_half_scale();
        test_latency(1, "latency");
        test_latency(3, "sparse");
        test_backpressure();
        test_reset_mid_comb();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
